// File: rtl/dly_pkg.sv
// -----------------------------------------------------------------------------
// dly_pkg
// Shared definitions for the delay-line select controller.
//   - Layout of each channel's 3-bit control field on DLY_CNTRL.
//   - Helper functions for the tap range and for parameter legality checks.
// -----------------------------------------------------------------------------
package dly_pkg;

    // Width of one channel's control field and the bit positions inside it.
    localparam int CNTRL_W      = 3;
    localparam int CNTRL_LOAD   = 2;
    localparam int CNTRL_ADJ    = 1;
    localparam int CNTRL_INCDEC = 0;

    // Largest value a tap counter of the given width can hold.
    function automatic int max_tap(input int tap_w);
        return (1 << tap_w) - 1;
    endfunction

    // True when a parameter set describes a legal controller.
    function automatic bit params_ok(input int num_dly, input int addr_w,
                                     input int tap_w, input int init_tap);
        return (num_dly >= 1) && (num_dly <= 32) &&
               (num_dly <= (1 << addr_w)) &&
               (tap_w >= 1) && (tap_w <= 30) &&
               (init_tap >= 0) && (init_tap <= max_tap(tap_w));
    endfunction

endpackage

// File: rtl/dly_tap_cnt.sv
// -----------------------------------------------------------------------------
// dly_tap_cnt
// Shadow tap counter for one delay channel. Loads a value or steps by one,
// saturating at 0 and MAX_TAP; all outputs are registered.
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   sel       in   this channel is addressed this cycle
//   load      in   load request (has priority over step)
//   step      in   qualified adjust request (one cycle per rising edge)
//   incdec    in   1 = increment, 0 = decrement
//   load_val  in   value taken on load
//   tap       out  current shadow tap value
//   step_done out  one-cycle pulse: a step was applied
//   sat       out  one-cycle pulse: a step was blocked by saturation
// -----------------------------------------------------------------------------
module dly_tap_cnt
    import dly_pkg::*;
#(
    parameter int TAP_W    = 6,
    parameter int INIT_TAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             load,
    input  logic             step,
    input  logic             incdec,
    input  logic [TAP_W-1:0] load_val,
    output logic [TAP_W-1:0] tap,
    output logic             step_done,
    output logic             sat
);

    localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(max_tap(TAP_W));

    // NOTE: reset is tested inside the clocked block, so it is synchronous and
    // only takes effect on a rising clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap       <= TAP_W'(INIT_TAP);
            step_done <= 1'b0;
            sat       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout the clocked logic, so
            // every register samples pre-edge values regardless of order.
            step_done <= 1'b0;
            sat       <= 1'b0;
            if (sel && load) begin
                tap <= load_val;
            end else if (sel && step) begin
                if (incdec) begin
                    if (tap != MAX_TAP) begin
                        tap       <= tap + 1'b1;
                        step_done <= 1'b1;
                    end else begin
                        sat <= 1'b1;
                    end
                end else begin
                    if (tap != '0) begin
                        tap       <= tap - 1'b1;
                        step_done <= 1'b1;
                    end else begin
                        sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dly_sel_ctrl.sv
// -----------------------------------------------------------------------------
// dly_sel_ctrl
// Registered delay-line select controller. Decodes one shared
// {load, adjust, incdec} command onto NUM_DLY per-channel control fields,
// edge-qualifies adjust requests and keeps a saturating shadow tap per channel.
//   CLK            in   clock, rising edge
//   RESET          in   synchronous active-low reset
//   DLY_LOAD       in   load request, level
//   DLY_ADJ        in   adjust request, acts on rising edge
//   DLY_INCDEC     in   1 = increment, 0 = decrement
//   DLY_ADDR       in   target channel
//   DLY_LOAD_VAL   in   value loaded into the shadow tap
//   DLY_CNTRL      out  channel k at [3k+2:3k] = {load, adj, incdec}
//   DLY_TAP_VALUE  out  channel k tap at [TAP_W*k +: TAP_W]
//   DLY_SAT        out  one-cycle pulse: adjust blocked by saturation
//   DLY_ADDR_ERR   out  one-cycle pulse: request to an out-of-range channel
// -----------------------------------------------------------------------------
module dly_sel_ctrl
    import dly_pkg::*;
#(
    parameter int NUM_DLY  = 20,
    parameter int ADDR_W   = 5,
    parameter int TAP_W    = 6,
    parameter int INIT_TAP = 0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       DLY_LOAD,
    input  logic                       DLY_ADJ,
    input  logic                       DLY_INCDEC,
    input  logic [ADDR_W-1:0]          DLY_ADDR,
    input  logic [TAP_W-1:0]           DLY_LOAD_VAL,
    output logic [CNTRL_W*NUM_DLY-1:0] DLY_CNTRL,
    output logic [TAP_W*NUM_DLY-1:0]   DLY_TAP_VALUE,
    output logic                       DLY_SAT,
    output logic                       DLY_ADDR_ERR
);

    if (!params_ok(NUM_DLY, ADDR_W, TAP_W, INIT_TAP)) begin : g_param_err
        $error("dly_sel_ctrl: illegal NUM_DLY/ADDR_W/TAP_W/INIT_TAP combination");
    end

    logic               adj_q;
    logic               adj_edge;
    logic               addr_valid;
    logic               addr_err_q;
    logic [NUM_DLY-1:0] sel;
    logic [NUM_DLY-1:0] load_q;
    logic [NUM_DLY-1:0] incdec_q;
    logic [NUM_DLY-1:0] step_done;
    logic [NUM_DLY-1:0] sat;

    // The edge is consumed on every cycle, whatever the address or load, so a
    // level held across an address change never steps the new channel.
    always_comb begin
        adj_edge   = DLY_ADJ & ~adj_q;
        addr_valid = 32'(DLY_ADDR) < NUM_DLY;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            adj_q      <= 1'b0;
            addr_err_q <= 1'b0;
            load_q     <= '0;
            incdec_q   <= '0;
        end else begin
            adj_q      <= DLY_ADJ;
            addr_err_q <= ~addr_valid & (DLY_LOAD | adj_edge);
            load_q     <= sel & {NUM_DLY{DLY_LOAD}};
            incdec_q   <= sel & {NUM_DLY{DLY_INCDEC}};
        end
    end

    for (genvar k = 0; k < NUM_DLY; k++) begin : g_chan
        assign sel[k] = addr_valid && (DLY_ADDR == ADDR_W'(k));

        dly_tap_cnt #(
            .TAP_W    (TAP_W),
            .INIT_TAP (INIT_TAP)
        ) u_tap_cnt (
            .clk       (CLK),
            .rst_n     (RESET),
            .sel       (sel[k]),
            .load      (DLY_LOAD),
            .step      (adj_edge),
            .incdec    (DLY_INCDEC),
            .load_val  (DLY_LOAD_VAL),
            .tap       (DLY_TAP_VALUE[TAP_W*k +: TAP_W]),
            .step_done (step_done[k]),
            .sat       (sat[k])
        );

        // The adj bit comes straight from the counter so it only pulses when
        // a step was actually applied (not on a load or a saturated request).
        assign DLY_CNTRL[CNTRL_W*k + CNTRL_LOAD]   = load_q[k];
        assign DLY_CNTRL[CNTRL_W*k + CNTRL_ADJ]    = step_done[k];
        assign DLY_CNTRL[CNTRL_W*k + CNTRL_INCDEC] = incdec_q[k];
    end

    // Only the addressed counter can flag saturation, so the OR is one-hot.
    assign DLY_SAT      = |sat;
    assign DLY_ADDR_ERR = addr_err_q;

endmodule

// File: doc/dly_sel_ctrl.md
# dly_sel_ctrl

Parametrised, registered delay-line select controller. It decodes a shared {DLY_LOAD, DLY_ADJ, DLY_INCDEC} command onto one of NUM_DLY per-channel 3-bit control buses. It edge-qualifies adjust requests and keeps a saturating shadow tap counter per channel. It sits between fabric delay-control logic and the I/O delay primitives, replacing the fixed 20-channel combinational decoder.

## Interface

Parameters:
- NUM_DLY, 20, number of delay channels (1..32)
- ADDR_W, 5, width of DLY_ADDR; must satisfy 2^ADDR_W >= NUM_DLY
- TAP_W, 6, tap counter width; MAX_TAP = 2^TAP_W-1
- INIT_TAP, 0, tap value after reset (<= MAX_TAP)

Ports:
- CLK  in  1  sole clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- DLY_LOAD  in  1  load request, level
- DLY_ADJ  in  1  adjust request; acts on its rising edge only
- DLY_INCDEC  in  1  1 = increment, 0 = decrement
- DLY_ADDR  in  ADDR_W  target channel
- DLY_LOAD_VAL  in  TAP_W  value loaded into shadow tap on load
- DLY_CNTRL  out  3*NUM_DLY  channel k at [3k+2:3k] = {load, adj, incdec}
- DLY_TAP_VALUE  out  TAP_W*NUM_DLY  channel k shadow tap at [TAP_W*k+:TAP_W]
- DLY_SAT  out  1  one-cycle pulse: adjust step blocked by saturation
- DLY_ADDR_ERR  out  1  one-cycle pulse: request with DLY_ADDR >= NUM_DLY

## Operation

- adj_q registers DLY_ADJ every cycle. adj_edge = DLY_ADJ & ~adj_q. The edge is consumed even if the address is invalid or a load is active.
- Valid address (DLY_ADDR < NUM_DLY), channel k = DLY_ADDR:
  - DLY_LOAD=1: tap[k] <= DLY_LOAD_VAL; load bit k = 1. Load has priority; a coincident adj_edge is discarded, with no adj pulse and no DLY_SAT.
  - DLY_LOAD=0, adj_edge, DLY_INCDEC=1:
    - tap[k] < MAX_TAP: tap[k]+1, adj bit k pulses.
    - tap[k] = MAX_TAP: tap unchanged, no adj pulse, DLY_SAT pulses.
  - DLY_LOAD=0, adj_edge, DLY_INCDEC=0:
    - tap[k] > 0: tap[k]-1, adj bit k pulses.
    - tap[k] = 0: tap unchanged, no adj pulse, DLY_SAT pulses.
  - incdec bit k = DLY_INCDEC whenever channel k is addressed.
- All non-addressed channels: control bits 0, taps hold.
- Invalid address: no DLY_CNTRL bit set and no tap changes. DLY_ADDR_ERR pulses if DLY_LOAD=1 or adj_edge.
- DLY_ADJ held high across an address change: no new edge, so no step on the new channel.
- Arithmetic is unsigned TAP_W-bit. No wrap-around is ever permitted.

## Timing

- Reset (RESET=0 at an edge):
  - DLY_CNTRL = 0, DLY_SAT = 0, DLY_ADDR_ERR = 0, adj_q = 0.
  - All taps = INIT_TAP.
  - Reset mid-adjust aborts any pending step.
  - A DLY_ADJ held high through reset release counts as one edge on the first cycle out of reset.
- Latency: inputs sampled at edge n. DLY_CNTRL, DLY_TAP_VALUE, DLY_SAT and DLY_ADDR_ERR reflect them after edge n; one-cycle registered latency, no combinational path input to output.
- The adj bit, DLY_SAT and DLY_ADDR_ERR are exactly one cycle wide per DLY_ADJ rising edge.
- The load bit stays high for every cycle DLY_LOAD=1 with a valid address.
- Back-to-back adjusts need DLY_ADJ low for at least one cycle between requests. Maximum rate is one step per 2 cycles.

## Structure

- Package dly_pkg:
  - DLY_CNTRL bit indices CNTRL_LOAD=2, CNTRL_ADJ=1, CNTRL_INCDEC=0.
  - CNTRL_W=3.
  - Elaboration-time parameter checks (NUM_DLY <= 2^ADDR_W, INIT_TAP <= MAX_TAP).
- Sub-module dly_tap_cnt:
  - One per channel via generate.
  - Inputs: sel, load, step, incdec, load_val.
  - Outputs: tap, step_done, sat.
- Top level holds the address decode, edge detect and error/saturation OR-reduction.

## Test plan

- Reset with INIT_TAP=5, NUM_DLY=20 -> all DLY_CNTRL 0, every tap 5, DLY_SAT/DLY_ADDR_ERR 0.
- ADDR=7, LOAD=1, LOAD_VAL=33 for 1 cycle -> next cycle tap[7]=33, DLY_CNTRL[23:21]=3'b100, other channels 0.
- ADDR=3, tap 62, three ADJ pulses with INCDEC=1 (ADJ low between pulses):
  - tap goes 63, 63, 63.
  - Adj bit pulses once.
  - DLY_SAT pulses on the 2nd and 3rd requests.
- ADDR=19, ADJ held high 10 cycles, INCDEC=0, tap 4 -> tap 3 only; one adj pulse.
- ADDR=25, LOAD=1 -> DLY_ADDR_ERR=1 one cycle later; no tap or control change anywhere.
- ADDR=2, LOAD=1 and ADJ rising same cycle, LOAD_VAL=10 -> tap[2]=10, control 3'b100 or 3'b101 per INCDEC, no adj pulse.
- 500 random cycles against a reference model, NUM_DLY=8, ADDR_W=3 -> zero mismatches.
